// File: rtl/bus_transfer_arbiter.sv
// Shared-bus transfer arbiter: grants one requester at a time and sequences reg_out/reg_in through SETUP, WRITE, DONE.
// Define BUS_ARB_FIXED_PRI_EN for lowest-index-wins priority; the default build is round-robin.
module bus_transfer_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned NREG = 16,
  parameter int unsigned IDXW = 4
) (
  input  logic                 clock,
  input  logic                 clear_n,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*IDXW-1:0] src_idx,
  input  logic [NREQ*IDXW-1:0] dst_idx,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      done,
  output logic                 err,
  output logic [NREG-1:0]      reg_out,
  output logic [NREG-1:0]      reg_in,
  output logic                 busy
);

  localparam int unsigned WW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_WRITE,
    S_DONE
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;

  logic [WW-1:0]   r_win;
  logic [IDXW-1:0] r_src;
  logic [IDXW-1:0] r_dst;
  logic            r_bad;

  logic [WW-1:0]   w_win;
  logic [WW-1:0]   w_j;
  logic            w_found;
  logic [IDXW-1:0] w_src;
  logic [IDXW-1:0] w_dst;
  logic            w_bad;

  logic [IDXW-1:0] w_src_arr [NREQ];
  logic [IDXW-1:0] w_dst_arr [NREQ];

  logic [NREQ-1:0] r_gnt,  w_gnt_nxt;
  logic [NREQ-1:0] r_done, w_done_nxt;
  logic            r_err,  w_err_nxt;
  logic [NREG-1:0] r_ro,   w_ro_nxt;
  logic [NREG-1:0] r_ri,   w_ri_nxt;
  logic            r_busy, w_busy_nxt;

  function automatic logic [NREQ-1:0] req_onehot(input logic [WW-1:0] idx);
    return NREQ'(1) << idx;
  endfunction

  function automatic logic [NREG-1:0] reg_onehot(input logic [IDXW-1:0] idx);
    return NREG'(1) << idx;
  endfunction

  // Unpack the per-requester index fields so the winner can select them directly
  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign w_src_arr[g] = src_idx[g*IDXW +: IDXW];
    assign w_dst_arr[g] = dst_idx[g*IDXW +: IDXW];
  end

`ifdef BUS_ARB_FIXED_PRI_EN
  // Lowest-index requester wins
  always_comb begin
    w_win   = '0;
    w_found = 1'b0;
    w_j     = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      w_j = WW'(k);
      if (!w_found && req[w_j]) begin
        w_win   = w_j;
        w_found = 1'b1;
      end
    end
  end
`else
  logic [WW-1:0] r_ptr;

  // Round-robin search starting at r_ptr, wrapping past NREQ-1
  always_comb begin
    w_win   = '0;
    w_found = 1'b0;
    w_j     = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      w_j = WW'((32'(r_ptr) + k) % NREQ);
      if (!w_found && req[w_j]) begin
        w_win   = w_j;
        w_found = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      r_ptr <= '0;
    end else if (r_state == S_IDLE && w_found) begin
      r_ptr <= WW'((32'(w_win) + 32'd1) % NREQ);
    end
  end
`endif

  assign w_src = w_src_arr[w_win];
  assign w_dst = w_dst_arr[w_win];
  assign w_bad = (32'(w_src) >= NREG) || (32'(w_dst) >= NREG);

  // State register
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and next-cycle outputs, decoded from the state being entered
  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = '0;
    w_done_nxt  = '0;
    w_err_nxt   = 1'b0;
    w_ro_nxt    = '0;
    w_ri_nxt    = '0;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_state_nxt = S_SETUP;
          w_gnt_nxt   = req_onehot(w_win);
          if (!w_bad) begin
            w_ro_nxt = reg_onehot(w_src);
          end
        end
      end
      S_SETUP: begin
        w_state_nxt = S_WRITE;
        w_gnt_nxt   = req_onehot(r_win);
        if (!r_bad) begin
          w_ro_nxt = reg_onehot(r_src);
          w_ri_nxt = reg_onehot(r_dst);
        end
      end
      S_WRITE: begin
        w_state_nxt = S_DONE;
        w_done_nxt  = req_onehot(r_win);
        w_err_nxt   = r_bad;
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  // Winner and indices are captured once, on the grant edge
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      r_win <= '0;
      r_src <= '0;
      r_dst <= '0;
      r_bad <= 1'b0;
    end else if (r_state == S_IDLE && w_found) begin
      r_win <= w_win;
      r_src <= w_src;
      r_dst <= w_dst;
      r_bad <= w_bad;
    end
  end

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      r_gnt  <= '0;
      r_done <= '0;
      r_err  <= 1'b0;
      r_ro   <= '0;
      r_ri   <= '0;
      r_busy <= 1'b0;
    end else begin
      r_gnt  <= w_gnt_nxt;
      r_done <= w_done_nxt;
      r_err  <= w_err_nxt;
      r_ro   <= w_ro_nxt;
      r_ri   <= w_ri_nxt;
      r_busy <= w_busy_nxt;
    end
  end

  assign gnt     = r_gnt;
  assign done    = r_done;
  assign err     = r_err;
  assign reg_out = r_ro;
  assign reg_in  = r_ri;
  assign busy    = r_busy;

endmodule

// File: tb/tb_bus_transfer_arbiter.sv
// Bench for bus_transfer_arbiter: vector table, hand-written corner sequences, then random traffic
// checked against a transfer-schedule model. NREG=12 so out-of-range indices are reachable.
module tb_bus_transfer_arbiter;

  localparam int NREQ = 4;
  localparam int NREG = 12;
  localparam int IDXW = 4;

  logic        clock   = 1'b0;
  logic        clear_n = 1'b1;
  logic [3:0]  req     = 4'h0;
  logic [15:0] src_idx = 16'h0;
  logic [15:0] dst_idx = 16'h0;
  logic [3:0]  gnt;
  logic [3:0]  done;
  logic        err;
  logic [11:0] reg_out;
  logic [11:0] reg_in;
  logic        busy;

  bus_transfer_arbiter #(.NREQ(NREQ), .NREG(NREG), .IDXW(IDXW)) dut (
    .clock   (clock),
    .clear_n (clear_n),
    .req     (req),
    .src_idx (src_idx),
    .dst_idx (dst_idx),
    .gnt     (gnt),
    .done    (done),
    .err     (err),
    .reg_out (reg_out),
    .reg_in  (reg_in),
    .busy    (busy)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [3:0]  gnt;
    logic [3:0]  done;
    logic        err;
    logic [11:0] ro;
    logic [11:0] ri;
    logic        busy;
  } outs_t;

  typedef struct {
    logic        clr;
    logic [3:0]  req;
    logic [15:0] src;
    logic [15:0] dst;
    outs_t       exp;
  } vec_t;

  int    n_chk  = 0;
  int    n_pass = 0;
  vec_t  tbl[$];
  outs_t mq[$];
  int    m_ptr  = 0;
  logic [3:0] active  = 4'h0;
  logic [3:0] dropped = 4'h0;

  localparam outs_t ZERO = '0;

  task automatic check(input string name, input outs_t exp);
    outs_t act;
    act = {gnt, done, err, reg_out, reg_in, busy};
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got gnt=%b done=%b err=%b reg_out=%h reg_in=%h busy=%b, want gnt=%b done=%b err=%b reg_out=%h reg_in=%h busy=%b",
                  name, act.gnt, act.done, act.err, act.ro, act.ri, act.busy,
                  exp.gnt, exp.done, exp.err, exp.ro, exp.ri, exp.busy);
  endtask

  function automatic vec_t mk(input logic clr, input logic [3:0] r, input logic [15:0] s, input logic [15:0] d,
                              input logic [3:0] g, input logic [3:0] dn, input logic e,
                              input logic [11:0] ro, input logic [11:0] ri, input logic b);
    vec_t v;
    v.clr = clr; v.req = r; v.src = s; v.dst = d;
    v.exp = {g, dn, e, ro, ri, b};
    return v;
  endfunction

  // One complete transfer: SETUP, WRITE, DONE with req held, then IDLE with the requester's follow-up req
  task automatic add_xfer(input logic [3:0] rh, input logic [3:0] ra, input logic [15:0] s, input logic [15:0] d,
                          input int w, input logic [11:0] ro, input logic [11:0] ri, input logic e);
    tbl.push_back(mk(1'b0, rh, s, d, 4'(1 << w), 4'h0, 1'b0, ro, 12'h0, 1'b1));
    tbl.push_back(mk(1'b0, rh, s, d, 4'(1 << w), 4'h0, 1'b0, ro, ri, 1'b1));
    tbl.push_back(mk(1'b0, rh, s, d, 4'h0, 4'(1 << w), e, 12'h0, 12'h0, 1'b1));
    tbl.push_back(mk(1'b0, ra, s, d, 4'h0, 4'h0, 1'b0, 12'h0, 12'h0, 1'b0));
  endtask

  task automatic apply(input string name, input vec_t v);
    req = v.req; src_idx = v.src; dst_idx = v.dst; clear_n = !v.clr;
    @(posedge clock); #1;
    check(name, v.exp);
    clear_n = 1'b1;
  endtask

  // Reference: when no transfer is outstanding and someone requests, schedule the next four output cycles
  task automatic model_edge(output outs_t e);
    int w;
    logic [3:0] s, d;
    logic ok;
    outs_t r;
    if (mq.size() == 0 && req != 4'h0) begin
      w = -1;
      for (int k = 0; k < NREQ; k++) begin
        int j;
`ifdef BUS_ARB_FIXED_PRI_EN
        j = k;
`else
        j = (m_ptr + k) % NREQ;
`endif
        if (w < 0 && req[j]) w = j;
      end
`ifndef BUS_ARB_FIXED_PRI_EN
      m_ptr = (w + 1) % NREQ;
`endif
      s  = src_idx[w*IDXW +: IDXW];
      d  = dst_idx[w*IDXW +: IDXW];
      ok = (int'(s) < NREG) && (int'(d) < NREG);
      r = '0; r.busy = 1'b1; r.gnt = 4'(1 << w);
      if (ok) r.ro = 12'(1 << s);
      mq.push_back(r);
      if (ok) r.ri = 12'(1 << d);
      mq.push_back(r);
      r = '0; r.busy = 1'b1; r.done = 4'(1 << w); r.err = !ok;
      mq.push_back(r);
      mq.push_back(ZERO);
    end
    e = (mq.size() != 0) ? mq.pop_front() : ZERO;
  endtask

  task automatic model_reset();
    mq.delete(); m_ptr = 0; active = 4'h0; dropped = 4'h0; req = 4'h0;
  endtask

  initial begin
    outs_t exp;

    // Vector table
    tbl.push_back(mk(1'b1, 4'h0, 16'h0, 16'h0, 4'h0, 4'h0, 1'b0, 12'h0, 12'h0, 1'b0));
    for (int i = 0; i < 10; i++)
      tbl.push_back(mk(1'b0, 4'h0, 16'h0, 16'h0, 4'h0, 4'h0, 1'b0, 12'h0, 12'h0, 1'b0));
    add_xfer(4'b0010, 4'b0000, 16'h0030, 16'h0070, 1, 12'h008, 12'h080, 1'b0);
    tbl.push_back(mk(1'b1, 4'h0, 16'h0, 16'h0, 4'h0, 4'h0, 1'b0, 12'h0, 12'h0, 1'b0));
    add_xfer(4'b1111, 4'b1110, 16'h3210, 16'h7654, 0, 12'h001, 12'h010, 1'b0);
    add_xfer(4'b1110, 4'b1100, 16'h3210, 16'h7654, 1, 12'h002, 12'h020, 1'b0);
    add_xfer(4'b1100, 4'b1000, 16'h3210, 16'h7654, 2, 12'h004, 12'h040, 1'b0);
    add_xfer(4'b1000, 4'b0000, 16'h3210, 16'h7654, 3, 12'h008, 12'h080, 1'b0);
    add_xfer(4'b0101, 4'b0100, 16'h3210, 16'h7654, 0, 12'h001, 12'h010, 1'b0);
    add_xfer(4'b0100, 4'b0000, 16'h3210, 16'h7654, 2, 12'h004, 12'h040, 1'b0);
    add_xfer(4'b0100, 4'b0000, 16'h0F00, 16'h0200, 2, 12'h000, 12'h000, 1'b1);
    add_xfer(4'b1000, 4'b0000, 16'h1000, 16'hC000, 3, 12'h000, 12'h000, 1'b1);
    add_xfer(4'b0001, 4'b0000, 16'h000B, 16'h000B, 0, 12'h800, 12'h800, 1'b0);
`ifdef BUS_ARB_FIXED_PRI_EN
    add_xfer(4'b1110, 4'b1110, 16'h3210, 16'h7654, 1, 12'h002, 12'h020, 1'b0);
    add_xfer(4'b1110, 4'b1110, 16'h3210, 16'h7654, 1, 12'h002, 12'h020, 1'b0);
`else
    add_xfer(4'b1110, 4'b1110, 16'h3210, 16'h7654, 1, 12'h002, 12'h020, 1'b0);
    add_xfer(4'b1110, 4'b1110, 16'h3210, 16'h7654, 2, 12'h004, 12'h040, 1'b0);
`endif
    tbl.push_back(mk(1'b0, 4'h0, 16'h0, 16'h0, 4'h0, 4'h0, 1'b0, 12'h0, 12'h0, 1'b0));

    #2 clear_n = 1'b0;
    #1 check("reset_async", ZERO);
    foreach (tbl[i]) apply($sformatf("vec%0d", i), tbl[i]);

    // Winner drops req and indices change during SETUP; latched values must be used
    apply("mid_setup", mk(1'b0, 4'b1000, 16'h5000, 16'h6000, 4'b1000, 4'h0, 1'b0, 12'h020, 12'h000, 1'b1));
    apply("mid_write", mk(1'b0, 4'b0000, 16'h9000, 16'hA000, 4'b1000, 4'h0, 1'b0, 12'h020, 12'h040, 1'b1));
    apply("mid_done",  mk(1'b0, 4'b0000, 16'h9000, 16'hA000, 4'h0, 4'b1000, 1'b0, 12'h000, 12'h000, 1'b1));
    apply("mid_idle",  mk(1'b0, 4'b0000, 16'h9000, 16'hA000, 4'h0, 4'h0, 1'b0, 12'h000, 12'h000, 1'b0));

    // Reset during WRITE: outputs clear at once, no done, pointer back at 0
    apply("rst_setup", mk(1'b0, 4'b0100, 16'h0100, 16'h0200, 4'b0100, 4'h0, 1'b0, 12'h002, 12'h000, 1'b1));
    apply("rst_write", mk(1'b0, 4'b0100, 16'h0100, 16'h0200, 4'b0100, 4'h0, 1'b0, 12'h002, 12'h004, 1'b1));
    clear_n = 1'b0;
    #1 check("rst_async", ZERO);
    apply("rst_hold",  mk(1'b1, 4'b0000, 16'h0100, 16'h0200, 4'h0, 4'h0, 1'b0, 12'h0, 12'h0, 1'b0));
    apply("rst_nodone", mk(1'b0, 4'b0000, 16'h0100, 16'h0200, 4'h0, 4'h0, 1'b0, 12'h0, 12'h0, 1'b0));
    apply("ptr_setup", mk(1'b0, 4'b1010, 16'h0040, 16'h0000, 4'b0010, 4'h0, 1'b0, 12'h010, 12'h000, 1'b1));
    apply("ptr_write", mk(1'b0, 4'b1010, 16'h0040, 16'h0000, 4'b0010, 4'h0, 1'b0, 12'h010, 12'h001, 1'b1));
    apply("ptr_done",  mk(1'b0, 4'b1010, 16'h0040, 16'h0000, 4'h0, 4'b0010, 1'b0, 12'h000, 12'h000, 1'b1));
    apply("ptr_idle",  mk(1'b0, 4'b1000, 16'h0040, 16'h0000, 4'h0, 4'h0, 1'b0, 12'h000, 12'h000, 1'b0));
    apply("r3_setup",  mk(1'b0, 4'b1000, 16'h0040, 16'h0000, 4'b1000, 4'h0, 1'b0, 12'h001, 12'h000, 1'b1));
    apply("r3_write",  mk(1'b0, 4'b1000, 16'h0040, 16'h0000, 4'b1000, 4'h0, 1'b0, 12'h001, 12'h001, 1'b1));
    apply("r3_done",   mk(1'b0, 4'b1000, 16'h0040, 16'h0000, 4'h0, 4'b1000, 1'b0, 12'h000, 12'h000, 1'b1));
    apply("r3_idle",   mk(1'b0, 4'b0000, 16'h0040, 16'h0000, 4'h0, 4'h0, 1'b0, 12'h000, 12'h000, 1'b0));

    // Random traffic against the schedule model
    clear_n = 1'b0;
    #1 clear_n = 1'b1;
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NREQ; i++)
        if (!active[i] && $urandom_range(0, 3) == 0) active[i] = 1'b1;
      req = active & ~dropped;
      if ($urandom_range(0, 1) == 0) src_idx = 16'($urandom());
      if ($urandom_range(0, 1) == 0) dst_idx = 16'($urandom());
      @(posedge clock);
      model_edge(exp);
      #1 check($sformatf("rand%0d", c), exp);
      for (int i = 0; i < NREQ; i++) begin
        if (exp.done[i]) begin
          active[i] = 1'b0; dropped[i] = 1'b0;
        end else if (exp.gnt[i] && $urandom_range(0, 7) == 0) begin
          dropped[i] = 1'b1;
        end
      end
      if ($urandom_range(0, 299) == 0) begin
        clear_n = 1'b0;
        #1 check($sformatf("rand_rst%0d", c), ZERO);
        clear_n = 1'b1;
        model_reset();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
